// File: rtl/hcsr04_trigger_ctrl.sv
// hcsr04_trigger_ctrl
// Transmit-side sequencer for an HC-SR04 ranging channel. It issues the TRIG
// pulse, waits for the echo block to start and finish timing the echo, and then
// holds off until the trigger-to-trigger period has elapsed. It runs either one
// shot per start request or back-to-back while continuous is held high.
module hcsr04_trigger_ctrl #(
   parameter int unsigned CLK_HZ            = 50000000,
   parameter int unsigned TRIG_TICKS        = 500,
   parameter int unsigned ARM_TIMEOUT_TICKS = 1500000,
   parameter int unsigned CYCLE_TICKS       = 3000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        continuous,
   input  logic        echo_busy,
   input  logic        echo_valid,
   input  logic        echo_timeout,
   output logic        trig_out,
   output logic        busy,
   output logic        no_echo,
   output logic        cycle_done,
   output logic [15:0] trig_count
);

   // Counter widths are fixed at 22 bits (cycle) and 21 bits (phase), so the
   // tick parameters must fit; a bad combination stops elaboration.
   if (CLK_HZ == 0 || TRIG_TICKS < 1 || ARM_TIMEOUT_TICKS < 1 ||
       TRIG_TICKS > 2097152 || ARM_TIMEOUT_TICKS > 2097152 ||
       CYCLE_TICKS > 4194304 ||
       CYCLE_TICKS <= TRIG_TICKS + ARM_TIMEOUT_TICKS) begin : g_bad_params
      $error("hcsr04_trigger_ctrl: inconsistent tick parameters");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_ARM,
      ST_MEAS,
      ST_HOLDOFF
   } state_t;

   localparam logic [20:0] TRIG_LAST = 21'(TRIG_TICKS - 1);
   localparam logic [20:0] ARM_LAST  = 21'(ARM_TIMEOUT_TICKS - 1);
   localparam logic [21:0] CYC_LAST  = 22'(CYCLE_TICKS - 1);

   state_t      state_q, state_d;
   logic        trig_q, trig_d;
   logic        busy_q, busy_d;
   logic        no_echo_q, no_echo_d;
   logic        cycle_done_q, cycle_done_d;
   logic [15:0] count_q, count_d;
   logic [21:0] cyc_q, cyc_d;
   logic [20:0] ph_q, ph_d;
   logic        launch;

   // Next-state logic: every flop has its next value decided here. A launch
   // (from IDLE or a continuous HOLDOFF exit) restarts both counters together
   // so the cycle counter measures time from the TRIG rising edge.
   always_comb begin
      state_d      = state_q;
      trig_d       = trig_q;
      no_echo_d    = 1'b0;
      cycle_done_d = 1'b0;
      count_d      = count_q;
      ph_d         = ph_q;
      cyc_d        = (cyc_q >= CYC_LAST) ? cyc_q : cyc_q + 22'd1;
      launch       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start || continuous) begin
               launch = 1'b1;
            end
         end
         ST_TRIG: begin
            if (ph_q == TRIG_LAST) begin
               trig_d  = 1'b0;
               state_d = ST_ARM;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + 21'd1;
            end
         end
         ST_ARM: begin
            if (echo_busy) begin
               state_d = ST_MEAS;
            end else if (echo_valid || echo_timeout) begin
               state_d = ST_HOLDOFF;
            end else if (ph_q == ARM_LAST) begin
               no_echo_d = 1'b1;
               state_d   = ST_HOLDOFF;
            end else begin
               ph_d = ph_q + 21'd1;
            end
         end
         ST_MEAS: begin
            if (echo_valid || echo_timeout) begin
               state_d = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (cyc_q >= CYC_LAST) begin
               cycle_done_d = 1'b1;
               if (continuous) begin
                  launch = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            trig_d  = 1'b0;
         end
      endcase

      if (launch) begin
         state_d = ST_TRIG;
         trig_d  = 1'b1;
         count_d = count_q + 16'd1;
         ph_d    = '0;
         cyc_d   = '0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset clears everything at once, so TRIG
   // drops as soon as rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         trig_q       <= 1'b0;
         busy_q       <= 1'b0;
         no_echo_q    <= 1'b0;
         cycle_done_q <= 1'b0;
         count_q      <= '0;
         cyc_q        <= '0;
         ph_q         <= '0;
      end else begin
         state_q      <= state_d;
         trig_q       <= trig_d;
         busy_q       <= busy_d;
         no_echo_q    <= no_echo_d;
         cycle_done_q <= cycle_done_d;
         count_q      <= count_d;
         cyc_q        <= cyc_d;
         ph_q         <= ph_d;
      end
   end

   assign trig_out   = trig_q;
   assign busy       = busy_q;
   assign no_echo    = no_echo_q;
   assign cycle_done = cycle_done_q;
   assign trig_count = count_q;

endmodule

// File: tb/tb_hcsr04_trigger_ctrl.sv
// tb_hcsr04_trigger_ctrl
// Drives the trigger controller with directed and random echo traffic and
// compares every output against a timestamp-based reference model.
module tb_hcsr04_trigger_ctrl;

   localparam int TRIG  = 5;
   localparam int ARM   = 20;
   localparam int CYCLE = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        echo_busy = 1'b0;
   logic        echo_valid = 1'b0;
   logic        echo_timeout = 1'b0;
   logic        trig_out;
   logic        busy;
   logic        no_echo;
   logic        cycle_done;
   logic [15:0] trig_count;

   int checks = 0;
   int passed = 0;

   // Reference model: everything is expressed as the age of the current
   // measurement, counted in cycles from the cycle TRIG went high.
   int          now = 0;
   int          rise_t = -100000;
   int          age;
   logic        m_active = 1'b0;
   logic        m_trig = 1'b0;
   logic        m_no_echo = 1'b0;
   logic        m_done = 1'b0;
   logic [15:0] m_count = '0;
   logic        echo_started = 1'b0;
   logic        echo_over = 1'b0;

   // Echo-block emulation settings
   logic echo_en = 1'b0;
   logic echo_rand = 1'b0;
   logic noise_en = 1'b0;
   int   e_delay = 0;
   int   e_len = 0;
   logic e_tmo = 1'b0;
   int   d_lo = 0, d_hi = 0, len_lo = 0, len_hi = 0;
   int   drv_rise = -1;
   int   drv_f;

   hcsr04_trigger_ctrl #(
      .CLK_HZ            (50000000),
      .TRIG_TICKS        (TRIG),
      .ARM_TIMEOUT_TICKS (ARM),
      .CYCLE_TICKS       (CYCLE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .continuous   (continuous),
      .echo_busy    (echo_busy),
      .echo_valid   (echo_valid),
      .echo_timeout (echo_timeout),
      .trig_out     (trig_out),
      .busy         (busy),
      .no_echo      (no_echo),
      .cycle_done   (cycle_done),
      .trig_count   (trig_count)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   task launch_model();
      m_active     = 1'b1;
      m_trig       = 1'b1;
      m_count      = m_count + 16'd1;
      rise_t       = now + 1;
      echo_started = 1'b0;
      echo_over    = 1'b0;
   endtask

   // Model update on each active edge, using the inputs held since the last negedge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         now = 0; rise_t = -100000; m_active = 1'b0; m_trig = 1'b0;
         m_no_echo = 1'b0; m_done = 1'b0; m_count = '0;
         echo_started = 1'b0; echo_over = 1'b0;
      end else begin
         m_no_echo = 1'b0;
         m_done    = 1'b0;
         age       = now - rise_t;
         if (!m_active) begin
            if (start || continuous) launch_model();
         end else if (age < TRIG) begin
            if (age == TRIG - 1) m_trig = 1'b0;
         end else if (!echo_over) begin
            if (echo_started) begin
               if (echo_valid || echo_timeout) echo_over = 1'b1;
            end else if (echo_busy) begin
               echo_started = 1'b1;
            end else if (echo_valid || echo_timeout) begin
               echo_over = 1'b1;
            end else if (age == TRIG + ARM - 1) begin
               echo_over = 1'b1;
               m_no_echo = 1'b1;
            end
         end else if (age >= CYCLE - 1) begin
            m_done = 1'b1;
            if (continuous) launch_model();
            else m_active = 1'b0;
         end
         now = now + 1;
      end
   end

   // Echo block emulation: busy starts e_delay cycles after TRIG falls, lasts
   // e_len cycles, then one end strobe; optional random stray strobes.
   always @(negedge clk) begin
      echo_busy    = 1'b0;
      echo_valid   = 1'b0;
      echo_timeout = 1'b0;
      if (echo_en && m_active && rst_n) begin
         if (rise_t != drv_rise) begin
            drv_rise = rise_t;
            if (echo_rand) begin
               e_delay = $urandom_range(d_lo, d_hi);
               e_len   = $urandom_range(len_lo, len_hi);
               e_tmo   = 1'($urandom_range(0, 1));
            end
         end
         drv_f     = rise_t + TRIG + e_delay;
         echo_busy = (now >= drv_f) && (now < drv_f + e_len);
         if (now == drv_f + e_len) begin
            if (e_tmo) echo_timeout = 1'b1;
            else echo_valid = 1'b1;
         end
      end
      if (noise_en && $urandom_range(0, 15) == 0) begin
         if ($urandom_range(0, 1) == 1) echo_valid = 1'b1;
         else echo_timeout = 1'b1;
      end
   end

   // Reset values, during reset and after release with no request
   task automatic test_reset();
      #12;
      checks++;
      if ({trig_out, busy, no_echo, cycle_done, trig_count} !== 20'h0) begin
         $display("[TB] FAIL reset_values: got %b/%b/%b/%b/%0d, need all zero",
                  trig_out, busy, no_echo, cycle_done, trig_count);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
            $display("[TB] FAIL reset_idle cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                     now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
         end else passed++;
      end
   endtask

   // Single shots with an echo that starts inside the arm window
   task automatic test_single_shot();
      int rise_obs, done_obs, done_n, high_n;
      logic prev_trig;
      logic [15:0] base;
      for (int s = 0; s < 3; s++) begin
         echo_en = 1'b1; echo_rand = 1'b0;
         e_delay = $urandom_range(0, 12);
         e_len   = $urandom_range(1, 30);
         e_tmo   = 1'($urandom_range(0, 1));
         base = m_count; rise_obs = -1; done_obs = -1; done_n = 0; high_n = 0; prev_trig = 1'b0;
         @(negedge clk);
         start = 1'b1;
         for (int i = 0; i < 112; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
               $display("[TB] FAIL single_shot cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                        now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
            end else passed++;
            if (trig_out && !prev_trig) rise_obs = now;
            prev_trig = trig_out;
            if (trig_out) high_n++;
            if (cycle_done) begin done_n++; done_obs = now; end
         end
         checks++;
         if (high_n != TRIG) $display("[TB] FAIL single_trig_width: got %0d cycles need %0d", high_n, TRIG);
         else passed++;
         checks++;
         if (done_n != 1 || done_obs - rise_obs != CYCLE)
            $display("[TB] FAIL single_done_time: got %0d pulses at rise+%0d need 1 at rise+%0d", done_n, done_obs - rise_obs, CYCLE);
         else passed++;
         checks++;
         if (busy !== 1'b0 || trig_count !== base + 16'd1)
            $display("[TB] FAIL single_end_state: got busy=%b count=%0d need busy=0 count=%0d", busy, trig_count, base + 16'd1);
         else passed++;
      end
   endtask

   // No echo at all: no_echo strobe after the arm window, then normal end
   task automatic test_no_echo();
      int rise_obs = -1, ne_obs = -1, ne_n = 0, done_obs = -1;
      logic prev_trig = 1'b0;
      echo_en = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
            $display("[TB] FAIL no_echo cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                     now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
         end else passed++;
         if (trig_out && !prev_trig) rise_obs = now;
         prev_trig = trig_out;
         if (no_echo) begin ne_n++; ne_obs = now; end
         if (cycle_done) done_obs = now;
      end
      checks++;
      if (ne_n != 1 || ne_obs - rise_obs != TRIG + ARM)
         $display("[TB] FAIL no_echo_time: got %0d pulses at rise+%0d need 1 at rise+%0d", ne_n, ne_obs - rise_obs, TRIG + ARM);
      else passed++;
      checks++;
      if (done_obs - rise_obs != CYCLE)
         $display("[TB] FAIL no_echo_done: got rise+%0d need rise+%0d", done_obs - rise_obs, CYCLE);
      else passed++;
   endtask

   // Continuous ranging with ignored start pulses; drop continuous in cycle 3 MEAS
   task automatic test_continuous();
      int rises[$];
      logic prev_trig = trig_out;
      logic [15:0] base = m_count;
      echo_en = 1'b1; echo_rand = 1'b1;
      d_lo = 0; d_hi = 14; len_lo = 5; len_hi = 40;
      @(negedge clk);
      continuous = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         checks++;
         if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
            $display("[TB] FAIL continuous cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                     now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
         end else passed++;
         if (trig_out && !prev_trig) rises.push_back(now);
         prev_trig = trig_out;
         if (continuous && (m_count - base) == 16'd3 && echo_started && !echo_over) continuous = 1'b0;
         start = continuous && ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      checks++;
      if (rises.size() != 3) $display("[TB] FAIL cont_rise_count: got %0d need 3", rises.size());
      else passed++;
      checks++;
      if (rises.size() < 3 || rises[1] - rises[0] != CYCLE || rises[2] - rises[1] != CYCLE)
         $display("[TB] FAIL cont_period: got %0d,%0d need %0d", (rises.size() >= 2) ? rises[1] - rises[0] : -1,
                  (rises.size() >= 3) ? rises[2] - rises[1] : -1, CYCLE);
      else passed++;
      checks++;
      if (busy !== 1'b0 || trig_count !== base + 16'd3)
         $display("[TB] FAIL cont_end_state: got busy=%b count=%0d need busy=0 count=%0d", busy, trig_count, base + 16'd3);
      else passed++;
   endtask

   // Echo longer than the cycle period: one-cycle holdoff then retrigger
   task automatic test_overrun();
      int rises[$];
      int done_first = -1, done_n = 0;
      logic prev_trig = trig_out;
      echo_en = 1'b1; echo_rand = 1'b0;
      e_delay = 2; e_len = 150; e_tmo = 1'b1;
      @(negedge clk);
      continuous = 1'b1;
      for (int i = 0; i < 360; i++) begin
         @(negedge clk);
         checks++;
         if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
            $display("[TB] FAIL overrun cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                     now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
         end else passed++;
         if (trig_out && !prev_trig) rises.push_back(now);
         prev_trig = trig_out;
         if (cycle_done) begin done_n++; if (done_first < 0) done_first = now; end
         if (rises.size() >= 2) continuous = 1'b0;
      end
      // rise, TRIG cycles, 2 arm cycles, 150 busy cycles, strobe cycle, one holdoff cycle
      checks++;
      if (rises.size() != 2 || rises[1] - rises[0] != TRIG + 2 + 150 + 2)
         $display("[TB] FAIL overrun_period: got %0d rises, gap %0d need 2, gap %0d", rises.size(),
                  (rises.size() >= 2) ? rises[1] - rises[0] : -1, TRIG + 2 + 150 + 2);
      else passed++;
      checks++;
      if (done_n != 2 || rises.size() < 2 || done_first != rises[1])
         $display("[TB] FAIL overrun_done: got %0d pulses first at %0d need 2 pulses first at retrigger", done_n, done_first);
      else passed++;
   endtask

   // Valid without busy, busy on the last arm cycle, start during MEAS
   task automatic test_corner_cases();
      int ne_n, done_n;
      logic [15:0] base;
      for (int k = 0; k < 3; k++) begin
         echo_en = 1'b1; echo_rand = 1'b0; e_tmo = 1'b0;
         case (k)
            0: begin e_delay = 3; e_len = 0; end
            1: begin e_delay = ARM - 1; e_len = 10; end
            default: begin e_delay = 4; e_len = 30; end
         endcase
         ne_n = 0; done_n = 0; base = m_count;
         @(negedge clk);
         start = 1'b1;
         for (int i = 0; i < 112; i++) begin
            @(negedge clk);
            checks++;
            if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
               $display("[TB] FAIL corner%0d cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                        k, now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
            end else passed++;
            if (no_echo) ne_n++;
            if (cycle_done) done_n++;
            start = (k == 2) && echo_started && !echo_over;
         end
         start = 1'b0;
         checks++;
         if (ne_n != 0 || done_n != 1 || trig_count !== base + 16'd1)
            $display("[TB] FAIL corner%0d_summary: got no_echo=%0d done=%0d count=%0d need 0,1,%0d",
                     k, ne_n, done_n, trig_count, base + 16'd1);
         else passed++;
      end
   endtask

   // Random start/continuous/echo traffic with stray strobes, then drain
   task automatic test_random_traffic();
      echo_en = 1'b1; echo_rand = 1'b1; noise_en = 1'b1;
      d_lo = 0; d_hi = 25; len_lo = 0; len_hi = 130;
      for (int i = 0; i < 1760; i++) begin
         @(negedge clk);
         checks++;
         if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
            $display("[TB] FAIL random cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                     now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
         end else passed++;
         if (i < 1500) begin
            start = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 149) == 0) continuous = ~continuous;
         end else begin
            start = 1'b0; continuous = 1'b0; noise_en = 1'b0;
         end
      end
      checks++;
      if (busy !== 1'b0) $display("[TB] FAIL random_drain: got busy=%b need 0", busy);
      else passed++;
   endtask

   // Reset between edges while TRIG is high, then a clean restart
   task automatic test_reset_mid_trig();
      int high_n = 0;
      echo_en = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({trig_out, busy, no_echo, cycle_done, trig_count} !== 20'h0)
         $display("[TB] FAIL reset_mid_trig: got %b/%b/%b/%b/%0d need all zero", trig_out, busy, no_echo, cycle_done, trig_count);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         checks++;
         if ({trig_out, busy, no_echo, cycle_done, trig_count} !== {m_trig, m_active, m_no_echo, m_done, m_count}) begin
            $display("[TB] FAIL restart cycle %0d: got %b/%b/%b/%b/%0d need %b/%b/%b/%b/%0d (trig/busy/no_echo/done/count)",
                     now, trig_out, busy, no_echo, cycle_done, trig_count, m_trig, m_active, m_no_echo, m_done, m_count);
         end else passed++;
         if (trig_out) high_n++;
      end
      checks++;
      if (high_n != TRIG || trig_count !== 16'd1)
         $display("[TB] FAIL restart_trig: got width=%0d count=%0d need %0d,1", high_n, trig_count, TRIG);
      else passed++;
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_single_shot();
      test_no_echo();
      test_continuous();
      test_overrun();
      test_corner_cases();
      test_random_traffic();
      test_reset_mid_trig();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
